// File: rtl/idwt_haar_non_pipelined_if.sv
// Handshake and data bundle for the inverse Haar DWT block.
//   start      : level request from the producer, sampled only while the block is idle
//   cA_in      : N/2 approximation coefficients, element k at [k*W +: W]
//   cD_in      : N/2 detail coefficients, element k at [k*W +: W]
//   array_out  : N reconstructed samples, sample j at [j*W +: W]
//   busy       : block is working through the coefficient pairs
//   done       : reconstruction complete, held until start drops
// master drives the request and coefficients; slave (the block) drives results and status.
interface idwt_haar_non_pipelined_if #(
   parameter int N = 8,
   parameter int W = 16
);
   logic                 start;
   logic [W*(N/2)-1:0]   cA_in;
   logic [W*(N/2)-1:0]   cD_in;
   logic [W*N-1:0]       array_out;
   logic                 busy;
   logic                 done;

   modport master (
      output start, cA_in, cD_in,
      input  array_out, busy, done
   );

   modport slave (
      input  start, cA_in, cD_in,
      output array_out, busy, done
   );
endinterface

// File: rtl/idwt_haar_non_pipelined.sv
// Inverse single-level Haar DWT, one coefficient pair at a time.
// Rebuilds N samples from N/2 approximation and N/2 detail coefficients:
//   x[2k]   = floor((a+d)*181/256), x[2k+1] = floor((a-d)*181/256), low W bits kept (wraps).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of idwt_haar_non_pipelined_if (start/cA_in/cD_in in,
//          array_out/busy/done out)
// A capture on start is followed by LOAD -> COMPUTE -> STORE per pair, so pair k
// lands 3(k+1) edges after the capture edge and DONE follows the last store.
module idwt_haar_non_pipelined #(
   parameter int N = 8,
   parameter int W = 16
) (
   input logic                       clk,
   input logic                       rst,
   idwt_haar_non_pipelined_if.slave  bus
);

   localparam int H  = N / 2;
   localparam int IW = (H > 1) ? $clog2(H) : 1;
   localparam int PW = W + 9;                    // 17b sum times 181 (8 bits) stays exact
   localparam logic [IW-1:0] LAST_IDX = IW'(H - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPUTE,
      S_STORE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     pair_idx_q, pair_idx_d;
   logic [W*H-1:0]    ca_s_q, ca_s_d;
   logic [W*H-1:0]    cd_s_q, cd_s_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      d_q, d_d;
   logic [W-1:0]      x0_q, x0_d;
   logic [W-1:0]      x1_q, x1_d;
   logic [W*N-1:0]    array_out_q, array_out_d;

   logic signed [W:0]    s, t;
   logic signed [PW-1:0] s_x, t_x, p, q;
   int unsigned          op_base, out_base;

   // Shared pair datapath: exact sum/difference, then *181 as shift-add.
   always_comb begin
      s   = $signed({a_q[W-1], a_q}) + $signed({d_q[W-1], d_q});
      t   = $signed({a_q[W-1], a_q}) - $signed({d_q[W-1], d_q});
      s_x = {{(PW-W-1){s[W]}}, s};
      t_x = {{(PW-W-1){t[W]}}, t};
      p   = (s_x <<< 7) + (s_x <<< 5) + (s_x <<< 4) + (s_x <<< 2) + s_x;
      q   = (t_x <<< 7) + (t_x <<< 5) + (t_x <<< 4) + (t_x <<< 2) + t_x;
   end

   always_comb begin
      state_d     = state_q;
      pair_idx_d  = pair_idx_q;
      ca_s_d      = ca_s_q;
      cd_s_d      = cd_s_q;
      a_d         = a_q;
      d_d         = d_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      array_out_d = array_out_q;
      op_base     = 32'(pair_idx_q) * 32'(W);
      out_base    = 32'(pair_idx_q) * 32'(2 * W);

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               ca_s_d      = bus.cA_in;
               cd_s_d      = bus.cD_in;
               array_out_d = '0;
               pair_idx_d  = '0;
               state_d     = S_LOAD;
            end
         end
         S_LOAD: begin
            a_d     = ca_s_q[op_base +: W];
            d_d     = cd_s_q[op_base +: W];
            state_d = S_COMPUTE;
         end
         S_COMPUTE: begin
            // Arithmetic shift right by 8 (floor), low W bits kept.
            x0_d    = W'(p >>> 8);
            x1_d    = W'(q >>> 8);
            state_d = S_STORE;
         end
         S_STORE: begin
            array_out_d[out_base +: W]     = x0_q;
            array_out_d[out_base + W +: W] = x1_q;
            if (pair_idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               pair_idx_d = pair_idx_q + IW'(1);
               state_d    = S_LOAD;
            end
         end
         S_DONE: begin
            if (!bus.start) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pair_idx_q  <= '0;
         ca_s_q      <= '0;
         cd_s_q      <= '0;
         a_q         <= '0;
         d_q         <= '0;
         x0_q        <= '0;
         x1_q        <= '0;
         array_out_q <= '0;
      end else begin
         state_q     <= state_d;
         pair_idx_q  <= pair_idx_d;
         ca_s_q      <= ca_s_d;
         cd_s_q      <= cd_s_d;
         a_q         <= a_d;
         d_q         <= d_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
         array_out_q <= array_out_d;
      end
   end

   assign bus.array_out = array_out_q;
   assign bus.busy      = (state_q == S_LOAD) || (state_q == S_COMPUTE) || (state_q == S_STORE);
   assign bus.done      = (state_q == S_DONE);

endmodule
